// File: rtl/wb_scoreboard.sv
// Per-register write scoreboard for the 5-stage pipeline; drives the ID-stage freeze.
// Optional macro FORWARDING_EN: hazard comes from a one-entry load tag instead of the counters.
module wb_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_wb_en,
  input  logic              issue_mem_r_en,
  input  logic [4:0]        issue_dest,
  input  logic [4:0]        src1,
  input  logic [4:0]        src2,
  input  logic              src2_valid,
  input  logic              retire_valid,
  input  logic [4:0]        retire_dest,
  output logic              hazard,
  output logic              busy,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Issue is taken only while ID is not frozen; the bubble carries no write.
  // Retire is a one-cycle strobe from WB with no back-pressure.
  logic [CNT_W-1:0] cnt [NREG];
  logic             accept;
  logic             rel;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic [NREG-1:0]  nz_vec;
  logic             ovf_hit;
  logic             unf_hit;

  always_comb begin
    accept = issue_valid && issue_wb_en && !hazard && (issue_dest != 5'd0);
    rel    = retire_valid && (retire_dest != 5'd0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    nz_vec  = '0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = accept && (issue_dest == 5'(r));
      dec_vec[r] = rel && (retire_dest == 5'(r));
      nz_vec[r]  = (cnt[r] != '0);
      if (inc_vec[r] && !dec_vec[r] && (cnt[r] == CNT_MAX)) ovf_hit = 1'b1;
      if (dec_vec[r] && !inc_vec[r] && (cnt[r] == '0))      unf_hit = 1'b1;
    end
    busy = |nz_vec;
  end

  // Simultaneous issue and retire on one register cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r] && (cnt[r] != CNT_MAX))
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
      if (ovf_hit) err_overflow  <= 1'b1;
      if (unf_hit) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (hazard && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end

`ifdef FORWARDING_EN
  // Only a load feeding the very next instruction stalls; the bubble clears the tag.
  logic       ld_v;
  logic [4:0] ld_dest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_v    <= 1'b0;
      ld_dest <= 5'd0;
    end else begin
      ld_v    <= accept && issue_mem_r_en;
      ld_dest <= issue_dest;
    end
  end

  always_comb begin
    hazard = ld_v && (ld_dest != 5'd0) &&
             ((src1 == ld_dest) || (src2_valid && (src2 == ld_dest)));
  end
`else
  logic unused_mem_r_en;
  logic pend1;
  logic pend2;

  assign unused_mem_r_en = issue_mem_r_en;

  // A same-cycle WB write to the source register counts as already released.
  always_comb begin
    pend1  = (src1 != 5'd0) &&
             (cnt[src1] > {{(CNT_W-1){1'b0}}, (rel && (retire_dest == src1))});
    pend2  = (src2 != 5'd0) &&
             (cnt[src2] > {{(CNT_W-1){1'b0}}, (rel && (retire_dest == src2))});
    hazard = pend1 || (src2_valid && pend2);
  end
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Table-driven bench for wb_scoreboard with an expected-value queue.
// Follows FORWARDING_EN so the same file covers both hazard rules.
module tb_wb_scoreboard;

  localparam int CW = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wb_en, issue_mem_r_en;
  logic [4:0]  issue_dest, src1, src2, retire_dest;
  logic        src2_valid, retire_valid;
  logic        hazard, busy, err_overflow, err_underflow;
  logic [15:0] stall_cycles;

  wb_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_mem_r_en(issue_mem_r_en), .issue_dest(issue_dest),
    .src1(src1), .src2(src2), .src2_valid(src2_valid),
    .retire_valid(retire_valid), .retire_dest(retire_dest),
    .hazard(hazard), .busy(busy), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, we, mr;
    logic [4:0]  id, s1, s2;
    logic        s2v, rv;
    logic [4:0]  rd;
    logic [CW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [CW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;

  function automatic logic [CW-1:0] pack(input logic h, b, ov, un, input logic [15:0] st);
    return {h, b, ov, un, st};
  endfunction

  function automatic void add(input logic iv, we, mr, input logic [4:0] id, s1, s2,
                              input logic s2v, rv, input logic [4:0] rd,
                              input logic h, b, ov, un, input logic [15:0] st);
    vec_t v;
    v.iv = iv; v.we = we; v.mr = mr; v.id = id; v.s1 = s1; v.s2 = s2;
    v.s2v = s2v; v.rv = rv; v.rd = rd; v.exp = pack(h, b, ov, un, st);
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_wb_en = v.we; issue_mem_r_en = v.mr;
    issue_dest = v.id; src1 = v.s1; src2 = v.s2; src2_valid = v.s2v;
    retire_valid = v.rv; retire_dest = v.rd;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb_en = 0; issue_mem_r_en = 0; issue_dest = 0;
    src1 = 0; src2 = 0; src2_valid = 0; retire_valid = 0; retire_dest = 0;
  endtask

  function automatic logic [CW-1:0] outs();
    return {hazard, busy, err_overflow, err_underflow, stall_cycles};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [CW-1:0] act);
    logic [CW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected value queued, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h (hazard,busy,ovf,unf,stall)", name, act, e);
      end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef FORWARDING_EN
    //  iv we mr id  s1 s2 s2v rv rd   h  b  ov un st
    add(0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0);  // reset state
    add(1, 1, 1, 9,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0);  // lw r9
    add(1, 1, 0, 10, 0, 9, 1,  0, 0,   1, 1, 0, 0, 0);  // use r9 via src2: stall
    add(1, 1, 0, 10, 0, 9, 1,  0, 0,   0, 1, 0, 0, 1);  // exactly one stall
    add(1, 1, 0, 9,  0, 0, 0,  0, 0,   0, 1, 0, 0, 1);  // add r9 (not a load)
    add(0, 0, 0, 0,  9, 9, 1,  0, 0,   0, 1, 0, 0, 1);  // use after add: no stall
    add(1, 1, 1, 0,  0, 0, 0,  0, 0,   0, 1, 0, 0, 1);  // lw r0 not tagged
    add(0, 0, 0, 0,  0, 0, 1,  0, 0,   0, 1, 0, 0, 1);  // r0 source never stalls
`else
    //  iv we mr id  s1 s2 s2v rv rd   h  b  ov un st
    add(0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0);  // reset state
    add(1, 1, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0);  // issue to r0
    add(0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0);  // r0 not tracked
    add(1, 1, 0, 5,  1, 2, 1,  0, 0,   0, 0, 0, 0, 0);  // add r5
    add(1, 1, 0, 6,  5, 0, 0,  0, 0,   1, 1, 0, 0, 0);  // RAW on r5, issue blocked
    add(1, 1, 0, 6,  5, 0, 0,  0, 0,   1, 1, 0, 0, 1);
    add(1, 1, 0, 6,  5, 0, 0,  1, 5,   0, 1, 0, 0, 2);  // WB write-through releases
    add(0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 1, 0, 0, 2);  // r6 pending
    add(0, 0, 0, 0,  0, 6, 0,  0, 0,   0, 1, 0, 0, 2);  // src2 not read
    add(0, 0, 0, 0,  0, 6, 1,  0, 0,   1, 1, 0, 0, 2);  // src2 read
    add(1, 1, 0, 7,  0, 0, 0,  1, 6,   0, 1, 0, 0, 3);  // retire r6, issue r7
    add(1, 1, 0, 7,  0, 0, 0,  1, 7,   0, 1, 0, 0, 3);  // issue+retire r7 same cycle
    add(0, 0, 0, 0,  7, 0, 0,  0, 0,   1, 1, 0, 0, 3);  // r7 still 1
    add(0, 0, 0, 0,  0, 0, 0,  1, 7,   0, 1, 0, 0, 4);  // drain r7
    add(0, 0, 0, 0,  7, 0, 0,  0, 0,   0, 0, 0, 0, 4);  // empty
    add(1, 1, 0, 3,  0, 0, 0,  0, 0,   0, 0, 0, 0, 4);  // r3 -> 1
    add(1, 1, 0, 3,  0, 0, 0,  0, 0,   0, 1, 0, 0, 4);  // r3 -> 2
    add(1, 1, 0, 3,  0, 0, 0,  0, 0,   0, 1, 0, 0, 4);  // r3 -> 3
    add(1, 1, 0, 3,  0, 0, 0,  0, 0,   0, 1, 0, 0, 4);  // saturated issue
    add(0, 0, 0, 0,  0, 0, 0,  1, 3,   0, 1, 1, 0, 4);  // r3 -> 2
    add(0, 0, 0, 0,  0, 0, 0,  1, 3,   0, 1, 1, 0, 4);  // r3 -> 1
    add(0, 0, 0, 0,  3, 0, 0,  1, 3,   0, 1, 1, 0, 4);  // r3 -> 0, write-through
    add(0, 0, 0, 0,  3, 0, 0,  0, 0,   0, 0, 1, 0, 4);  // held at 3, so drained
    add(0, 0, 0, 0,  0, 0, 0,  1, 3,   0, 0, 1, 0, 4);  // retire on zero counter
    add(0, 0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 1, 1, 4);  // sticky flags; r0 retire ignored
    add(0, 0, 0, 0,  3, 0, 0,  0, 0,   0, 0, 1, 1, 4);  // still 0 after underflow
`endif

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs());
    end

    // async reset in the middle of a stall with r4 counted twice
    @(posedge clk); #1 idle(); issue_valid = 1; issue_wb_en = 1; issue_mem_r_en = 1; issue_dest = 4;
    @(posedge clk); #1;
    @(posedge clk); #1 idle(); src1 = 4;
    exp_q.push_back(CW'(1));
    @(negedge clk);
    check("pre_reset_hazard", CW'(hazard));
    #2 rst_n = 1'b0;
    exp_q.push_back('0);
    #1 check("async_reset_outs", outs());
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    check("post_reset_src4", outs());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Per-register scoreboard for the 5-stage MIPS pipeline; it is the write-side tracker that feeds the ID-stage stall decision.
- Records every destination register issued from ID with write-back enabled, and releases it when WB commits.
- Produces the ID-stage hazard/freeze signal from the current source operands.
- Its output drives the bubble mux and the PC/IF-ID freeze.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hard-wired zero and never tracked.
- CNT_W, 2, width of each in-flight counter; maximum outstanding writes per register = 2^CNT_W-1.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  ID holds a real instruction this cycle
- issue_wb_en  in  1  issued instruction writes a register
- issue_mem_r_en  in  1  issued instruction is a load
- issue_dest  in  5  destination register of issued instruction
- src1  in  5  ID source operand 1
- src2  in  5  ID source operand 2
- src2_valid  in  1  src2 is actually read (0 for immediate forms)
- retire_valid  in  1  WB stage commits a register write
- retire_dest  in  5  register written by WB
- hazard  out  1  freeze PC/IF-ID and insert bubble into ID/EXE
- busy  out  1  at least one counter nonzero
- err_overflow  out  1  sticky: issue attempted on a saturated counter
- err_underflow  out  1  sticky: retire on a zero counter
- stall_cycles  out  PERF_W  saturating count of cycles with hazard=1

Behaviour:
- Issue acceptance: accept = issue_valid & issue_wb_en & ~hazard & (issue_dest!=0).
  - An instruction presented while hazard=1 is not recorded; the bubble carries no write.
- Retire release: rel = retire_valid & (retire_dest!=0).
- Counter update, registered on the rising clk edge, for register r:
  - +1 if accept hits r only.
  - -1 if rel hits r only.
  - Unchanged if both hit r in the same cycle (net zero), or if neither hits.
  - Accept and retire on different registers update independently in the same cycle.
- Saturation, counter at max with accept only:
  - Counter holds.
  - err_overflow sets on that edge.
- Underflow, counter at 0 with rel only:
  - Counter holds 0.
  - err_underflow sets on that edge.
- Error flags are sticky until reset.
- hazard is combinational, zero-latency from src1/src2/src2_valid/retire_*, and from registered state. The rule is selected by the optional feature below.
- Effective pending for register s:
  - pend(s) = (cnt[s] - (rel & retire_dest==s)) > 0.
  - Same-cycle WB write-through clears the hazard.
- src1==0, or src2==0 when src2_valid, never causes hazard.
- busy = OR of all counters != 0, taken from registered state.
- stall_cycles increments on each edge where hazard=1 and holds at all-ones.
- Reset, asynchronous and at any time including mid-stall:
  - All counters clear to 0; load tag clears.
  - hazard=0, busy=0, err_overflow=0, err_underflow=0, stall_cycles=0.
  - In-flight instructions after reset are the pipeline's responsibility; their later retires raise err_underflow.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined (forwarding mode):
  - A one-entry load tag (ld_v, ld_dest) is registered every edge.
  - ld_v <= accept & issue_mem_r_en; ld_dest <= issue_dest.
  - hazard = ld_v & ((src1==ld_dest) | (src2_valid & src2==ld_dest)) & (ld_dest!=0).
  - Because the bubble clears ld_v, a load-use produces exactly one stall cycle.
  - Counters are still maintained for busy and the error flags.
- Undefined (no forwarding):
  - hazard = pend(src1) | (src2_valid & pend(src2)).
  - The load tag logic is absent.

Test Plan:
- No-forward RAW: issue add with dest=5. Next cycle src1=5, no retire -> hazard=1, and it stays 1 until the cycle retire_dest=5 arrives, in which hazard=0. stall_cycles equals the number of stalled cycles.
- Same-cycle issue and retire on r7 with cnt[7]=1 -> cnt[7] stays 1, no error flags.
- Saturation: three accepted issues to r3 with no retire, then a fourth -> cnt[3]=3 holds, err_overflow=1. Retire r3 with cnt=0 after draining -> err_underflow=1.
- r0 handling: issue_dest=0 and src1=0 -> no count change, hazard=0, busy=0.
- FORWARDING_EN load-use: lw with dest=9, next cycle src2=9 and src2_valid=1 -> hazard=1 for exactly one cycle, then 0. An add with dest=9 followed by a use -> hazard=0.
- Async reset asserted while hazard=1 with cnt[4]=2 -> all outputs 0 immediately, before the next clk edge; after reset release, src1=4 gives hazard=0.
